data_memory_sync: RTL and testbench
===================================

# data_memory_sync

Synchronous, parametrised successor to the datapath's byte-addressable data memory. Requests enter through a valid/ready handshake, writes commit on the accepting clock edge, and reads return one cycle later with optional sign extension. After reset, a clear engine zeroes the array, and the block reports misaligned, out-of-range and conflicting accesses. It sits in the MEM stage between the ALU result / rt-forwarding path and the write-back mux.

## Interface
Parameters:
- DEPTH, 256: array size in bytes; must be a power of two and ≥ 4.
- ADDR_WIDTH, 32: width of Address. Only the low log2(DEPTH) bits index the array; higher bits are range-checked.

Ports (bit numbering MSB-first, [0:N-1], as elsewhere in the datapath):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request this cycle.
- Address  in  ADDR_WIDTH  byte address of the first (most significant) byte.
- WriteData  in  32  store data; the low bytes are used for byte and half accesses.
- MemWrite  in  2  0 = none, 1 = byte, 2 = half, 3 = word.
- MemRead  in  2  0 = none, 1 = byte, 2 = half, 3 = word.
- MemSigned  in  1  sign-extend byte/half read data when high.
- RespValid  out  1  one-cycle pulse: response for the previously accepted request.
- ReadData  out  32  read result; 0 for writes and errors.
- RespError  out  1  qualifies RespValid; the access was suppressed.
- ErrCount  out  8  saturating count of error responses since reset.

## Operation
- Storage is a big-endian byte array: Memory[Address] maps to the most significant byte of the accessed field.
- FSM states:
  - CLEAR: entered on reset. A word counter runs from 0 to DEPTH/4-1 and zeroes 4 bytes per cycle. At the last count the FSM moves to READY. ReqReady=0 throughout.
  - READY: ReqReady=1. A request is accepted when ReqValid && ReqReady.
- An accepted request with MemWrite=MemRead=0 is a no-op. It still produces RespValid with RespError=0 and ReadData=0.
- Write: bytes commit at the accepting edge. A byte write stores WriteData[24:31]; a half write stores [16:31]; a word write stores [0:31] at Address..Address+3.
- Read: the array is sampled at the accepting edge and the result is presented next cycle.
  - Byte data goes to ReadData[24:31] and half data to [16:31].
  - Upper bits are zero, or copies of the field MSB when MemSigned=1.
  - A word read ignores MemSigned.
- Error conditions suppress the write and force ReadData=0 with RespError=1:
  - MemWrite≠0 and MemRead≠0 in the same request;
  - Address ≥ DEPTH, or the last byte of the access ≥ DEPTH (no wrap-around);
  - misaligned access (see Configuration).
- ErrCount increments on each error response and saturates at 255.

## Timing
- Reset values: ReqReady=0, RespValid=0, RespError=0, ReadData=0, ErrCount=0, FSM=CLEAR, counter=0.
- Clear takes exactly DEPTH/4 cycles after reset deasserts: 64 cycles for DEPTH=256. ReqReady rises in cycle DEPTH/4.
- Latency is 1: a request accepted at edge N gets RespValid high during cycle N+1 only. There is no response backpressure.
- Full throughput: one request per cycle with no bubbles.
- A read accepted one cycle after a write to the same bytes returns the new data.
- Reset asserted mid-clear or mid-response restarts CLEAR, drops any pending response and discards the array contents.
- ReqValid while ReqReady=0 is ignored. The requester must hold the request.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - a half access with Address[0]≠0, or a word access with Address[1:0]≠0, is an error;
  - the access is suppressed, and RespError and ErrCount behave as above.
- DMEM_ALIGN_CHECK_EN undefined:
  - misaligned accesses are performed byte-wise at Address..Address+size-1;
  - only the conflict and range checks raise errors.

## Test plan
- Reset, deassert, count cycles: ReqReady=0 for 64 cycles, then 1. A word read of address 0x10 then returns 0x00000000 with RespError=0.
- Word write 0xDEADBEEF at 0x20, then on the next cycle a byte read at 0x20 with MemSigned=1: ReadData=0xFFFFFFDE. A half read at 0x22 with MemSigned=0: 0x0000BEEF.
- Back-to-back writes 0x11223344 to 0x0, 0x4, 0x8 followed by three reads: RespValid high for 6 consecutive cycles, all reads return 0x11223344.
- Word write at 0xFE with DEPTH=256: RespError=1, ErrCount=1, bytes 0xFE–0xFF unchanged. MemWrite=3 with MemRead=3 at 0x0: RespError=1, ErrCount=2.
- Half write 0xABCD at 0x31. With DMEM_ALIGN_CHECK_EN: RespError=1 and a word read of 0x30 returns 0. Without it: a word read of 0x30 returns 0x00ABCD00.
- Assert reset at cycle 30 of clear, then release: ReqReady rises exactly 64 cycles after release and no RespValid occurs in between.

Source files
------------

// File: rtl/data_memory_sync_if.sv
// Request/response bus of the MEM-stage data memory.
// Bit numbering is MSB-first ([0:N-1]) to match the rest of the datapath.
interface data_memory_sync_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  ReqValid;
  logic                  ReqReady;
  logic [0:ADDR_WIDTH-1] Address;
  logic [0:31]           WriteData;
  logic [0:1]            MemWrite;
  logic [0:1]            MemRead;
  logic                  MemSigned;
  logic                  RespValid;
  logic [0:31]           ReadData;
  logic                  RespError;
  logic [0:7]            ErrCount;

  // Requester side (pipeline MEM stage)
  modport master (
    output ReqValid, Address, WriteData, MemWrite, MemRead, MemSigned,
    input  ReqReady, RespValid, ReadData, RespError, ErrCount
  );

  // Memory side
  modport slave (
    input  ReqValid, Address, WriteData, MemWrite, MemRead, MemSigned,
    output ReqReady, RespValid, ReadData, RespError, ErrCount
  );
endinterface

// File: rtl/data_memory_sync.sv
// Synchronous big-endian byte-addressable data memory with a post-reset
// clear engine, one-cycle read latency and error reporting.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned half/word
// accesses become errors instead of being performed byte-wise).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | zeroing the array one word per cycle, requests not accepted
// S_READY | accepting one request per cycle
module data_memory_sync #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_sync_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int WORDS = DEPTH / 4;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] clr_cnt;
  logic [IDX_W-1:0] clr_base;
  logic             ready;
  logic             clearing;

  logic [7:0] mem [DEPTH];

  // Request fields copied into descending vectors so bit 0 is the LSB
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [1:0]            wr_sz;
  logic [1:0]            rd_sz;
  logic                  sgn;

  logic [1:0]            acc_sz;
  logic [2:0]            nbytes;
  logic [ADDR_WIDTH:0]   last_byte;
  logic                  conflict;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  req_err;
  logic                  accept;
  logic                  wr_commit;

  logic [IDX_W-1:0]      idx;
  logic [7:0]            rb0, rb1, rb2, rb3;
  logic [31:0]           rd_field;

  logic                  resp_valid;
  logic                  resp_error;
  logic [31:0]           read_data;
  logic [7:0]            err_count;

  assign addr  = bus.Address;
  assign wdata = bus.WriteData;
  assign wr_sz = bus.MemWrite;
  assign rd_sz = bus.MemRead;
  assign sgn   = bus.MemSigned;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  // Next state: leave CLEAR once the last word has been zeroed
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_cnt == CNT_LAST) state_nxt = S_READY;
      S_READY: state_nxt = S_READY;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready    = 1'b0;
    clearing = 1'b0;
    case (state)
      S_CLEAR: clearing = 1'b1;
      S_READY: ready    = 1'b1;
      default: clearing = 1'b1;
    endcase
  end

  // Clear word counter, restarts from 0 on every reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      clr_cnt <= '0;
    else if (clearing)
      clr_cnt <= (clr_cnt == CNT_LAST) ? '0 : clr_cnt + CNT_W'(1);
  end

  assign clr_base = IDX_W'({clr_cnt, 2'b00});

  // ---------------------------------------------------------------------
  // Request decode and error checks
  // ---------------------------------------------------------------------

  assign acc_sz = (wr_sz != 2'd0) ? wr_sz : rd_sz;

  // Access size in bytes; 0 for a no-op
  always_comb begin
    nbytes = 3'd0;
    case (acc_sz)
      2'd1:    nbytes = 3'd1;
      2'd2:    nbytes = 3'd2;
      2'd3:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  end

  // One extra bit keeps Address+size-1 from wrapping back into range
  assign last_byte    = {1'b0, addr} + (ADDR_WIDTH + 1)'(nbytes - 3'd1);
  assign conflict     = (wr_sz != 2'd0) && (rd_sz != 2'd0);
  assign out_of_range = (acc_sz != 2'd0) &&
                        (({1'b0, addr} >= DEPTH_X) || (last_byte >= DEPTH_X));

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = ((acc_sz == 2'd2) && addr[0]) ||
                      ((acc_sz == 2'd3) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_err   = conflict || out_of_range || misaligned;
  assign accept    = bus.ReqValid && ready;
  assign wr_commit = accept && (wr_sz != 2'd0) && !req_err;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------

  assign idx = addr[IDX_W-1:0];

  // Byte-wise access lets misaligned fields straddle word boundaries
  assign rb0 = mem[idx];
  assign rb1 = mem[idx + IDX_W'(1)];
  assign rb2 = mem[idx + IDX_W'(2)];
  assign rb3 = mem[idx + IDX_W'(3)];

  // Array update: clear engine while clearing, committed stores otherwise
  always_ff @(posedge clk) begin
    if (clearing) begin
      for (int i = 0; i < 4; i++)
        mem[clr_base + IDX_W'(i)] <= 8'h00;
    end else if (wr_commit) begin
      case (wr_sz)
        2'd1: mem[idx] <= wdata[7:0];
        2'd2: begin
          mem[idx]              <= wdata[15:8];
          mem[idx + IDX_W'(1)]  <= wdata[7:0];
        end
        2'd3: begin
          mem[idx]              <= wdata[31:24];
          mem[idx + IDX_W'(1)]  <= wdata[23:16];
          mem[idx + IDX_W'(2)]  <= wdata[15:8];
          mem[idx + IDX_W'(3)]  <= wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // Read field alignment and optional sign extension; zero when not reading
  always_comb begin
    rd_field = 32'h0;
    case (rd_sz)
      2'd1:    rd_field = {{24{sgn & rb0[7]}}, rb0};
      2'd2:    rd_field = {{16{sgn & rb0[7]}}, rb0, rb1};
      2'd3:    rd_field = {rb0, rb1, rb2, rb3};
      default: rd_field = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Response
  // ---------------------------------------------------------------------

  // One-cycle response for every accepted request; errors return zero data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      read_data  <= 32'h0;
    end else begin
      resp_valid <= accept;
      resp_error <= accept && req_err;
      read_data  <= (accept && !req_err) ? rd_field : 32'h0;
    end
  end

  // Saturating error counter, updated together with the error response
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_count <= 8'h00;
    else if (accept && req_err && (err_count != 8'hFF))
      err_count <= err_count + 8'h01;
  end

  assign bus.ReqReady  = ready;
  assign bus.RespValid = resp_valid;
  assign bus.RespError = resp_error;
  assign bus.ReadData  = read_data;
  assign bus.ErrCount  = err_count;

endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench for data_memory_sync: directed scenarios plus a
// randomized run against a byte-array reference model.
module tb_data_memory_sync;
  localparam int DEPTH = 256;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] ref_mem [DEPTH];
  int         ref_errcnt;

  data_memory_sync_if #(.ADDR_WIDTH(AW)) bus ();

  data_memory_sync #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Reference model --------------------------------------------------------
  function automatic void model_reset();
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    ref_errcnt = 0;
  endfunction

  function automatic void model_req(input int w, input int r, input bit sg,
                                    input longint unsigned a, input logic [31:0] d,
                                    output bit err, output logic [31:0] rd);
    int          sz;
    int          n;
    int          base;
    logic [63:0] val;
    sz  = (w != 0) ? w : r;
    n   = (sz == 3) ? 4 : sz;
    err = 1'b0;
    rd  = 32'h0;
    if (w != 0 && r != 0) err = 1'b1;
    if (n != 0 && (a + longint'(n) - 1) >= longint'(DEPTH)) err = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
    if (n > 1 && (a % longint'(n)) != 0) err = 1'b1;
`endif
    if (err) begin
      if (ref_errcnt < 255) ref_errcnt++;
      return;
    end
    base = int'(a);
    if (w != 0) begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*(n-1-i) +: 8];
    end else if (r != 0) begin
      val = 64'h0;
      for (int i = 0; i < n; i++) val = (val << 8) | 64'(ref_mem[base + i]);
      if (sg && n < 4 && val[8*n-1]) val = val | ({64{1'b1}} << (8*n));
      rd = val[31:0];
    end
  endfunction

  // Stimulus plumbing ------------------------------------------------------
  task automatic drive(input bit v, input int w, input int r, input bit sg,
                       input logic [31:0] a, input logic [31:0] d);
    bus.ReqValid  = v;
    bus.MemWrite  = 2'(w);
    bus.MemRead   = 2'(r);
    bus.MemSigned = sg;
    bus.Address   = a;
    bus.WriteData = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scenarios --------------------------------------------------------------
  task automatic test_reset();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    reset = 1'b1;
    tick(); tick(); tick();
    model_reset();
    checks++; if (bus.ReqReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ReqReady); end
    checks++; if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL reset_respvalid: got %b want 0", bus.RespValid); end
    checks++; if (bus.RespError !== 1'b0) begin errors++; $display("FAIL reset_resperror: got %b want 0", bus.RespError); end
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 00000000", bus.ReadData); end
    checks++; if (bus.ErrCount !== 8'h0) begin errors++; $display("FAIL reset_errcount: got %0d want 0", bus.ErrCount); end
    // Held request during clear must be ignored
    drive(1, 3, 0, 0, 32'h10, 32'hCAFEF00D);
    reset = 1'b0;
    checks++; if (bus.ReqReady !== 1'b0) begin errors++; $display("FAIL clear_ready_c0: got %b want 0", bus.ReqReady); end
    for (int k = 1; k <= DEPTH/4; k++) begin
      tick();
      checks++;
      if (bus.ReqReady !== ((k == DEPTH/4) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL clear_ready_c%0d: got %b want %b", k, bus.ReqReady, (k == DEPTH/4));
      end
      checks++;
      if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL clear_respvalid_c%0d: got %b want 0", k, bus.RespValid); end
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_clear_read();
    bit e_err; logic [31:0] e_rd;
    drive(1, 0, 3, 0, 32'h10, 32'h0);
    model_req(0, 3, 0, 64'h10, 32'h0, e_err, e_rd);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (bus.RespValid !== 1'b1) begin errors++; $display("FAIL clear_read_valid: got %b want 1", bus.RespValid); end
    checks++; if (bus.RespError !== 1'b0) begin errors++; $display("FAIL clear_read_err: got %b want 0", bus.RespError); end
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL clear_read_data: got %h want 00000000", bus.ReadData); end
    tick();
    checks++; if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL clear_read_pulse: got %b want 0", bus.RespValid); end
  endtask

  task automatic test_rw_sign();
    bit e_err; logic [31:0] e_rd;
    drive(1, 3, 0, 0, 32'h20, 32'hDEADBEEF);
    model_req(3, 0, 0, 64'h20, 32'hDEADBEEF, e_err, e_rd);
    tick();
    checks++; if (bus.RespValid !== 1'b1 || bus.RespError !== 1'b0 || bus.ReadData !== 32'h0) begin
      errors++; $display("FAIL word_write_resp: got v=%b e=%b d=%h want v=1 e=0 d=00000000", bus.RespValid, bus.RespError, bus.ReadData); end
    drive(1, 0, 1, 1, 32'h20, 32'h0);
    model_req(0, 1, 1, 64'h20, 32'h0, e_err, e_rd);
    tick();
    checks++; if (bus.ReadData !== 32'hFFFFFFDE) begin errors++; $display("FAIL byte_read_signed: got %h want FFFFFFDE", bus.ReadData); end
    checks++; if (bus.RespValid !== 1'b1) begin errors++; $display("FAIL byte_read_valid: got %b want 1", bus.RespValid); end
    drive(1, 0, 2, 0, 32'h22, 32'h0);
    model_req(0, 2, 0, 64'h22, 32'h0, e_err, e_rd);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (bus.ReadData !== 32'h0000BEEF) begin errors++; $display("FAIL half_read_unsigned: got %h want 0000BEEF", bus.ReadData); end
    tick();
    checks++; if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL rw_sign_idle: got %b want 0", bus.RespValid); end
  endtask

  task automatic test_back_to_back();
    bit e_err; logic [31:0] e_rd;
    logic [31:0] a;
    bit          is_wr;
    for (int i = 0; i < 6; i++) begin
      is_wr = (i < 3);
      a = 32'(4 * (i % 3));
      drive(1, is_wr ? 3 : 0, is_wr ? 0 : 3, 0, a, 32'h11223344);
      model_req(is_wr ? 3 : 0, is_wr ? 0 : 3, 0, 64'(a), 32'h11223344, e_err, e_rd);
      tick();
      checks++; if (bus.RespValid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d: got %b want 1", i, bus.RespValid); end
      checks++; if (bus.ReadData !== (is_wr ? 32'h0 : 32'h11223344)) begin
        errors++; $display("FAIL b2b_data_%0d: got %h want %h", i, bus.ReadData, (is_wr ? 32'h0 : 32'h11223344)); end
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    checks++; if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", bus.RespValid); end
  endtask

  task automatic test_errors();
    bit e_err; logic [31:0] e_rd;
    int          w_t [5] = '{3, 0, 3, 0, 0};
    int          r_t [5] = '{0, 2, 3, 1, 3};
    logic [31:0] a_t [5] = '{32'hFE, 32'hFE, 32'h0, 32'h100, 32'h8000_0000};
    int          c_t [5] = '{1, 1, 2, 3, 4};
    for (int i = 0; i < 5; i++) begin
      drive(1, w_t[i], r_t[i], 0, a_t[i], 32'h12345678);
      model_req(w_t[i], r_t[i], 0, 64'(a_t[i]), 32'h12345678, e_err, e_rd);
      tick();
      checks++; if (bus.RespError !== e_err) begin errors++; $display("FAIL err_flag_%0d: got %b want %b", i, bus.RespError, e_err); end
      checks++; if (bus.ReadData !== e_rd) begin errors++; $display("FAIL err_data_%0d: got %h want %h", i, bus.ReadData, e_rd); end
      checks++; if (bus.ErrCount !== 8'(c_t[i])) begin errors++; $display("FAIL err_count_%0d: got %0d want %0d", i, bus.ErrCount, c_t[i]); end
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_misalign();
    bit e_err; logic [31:0] e_rd;
    bit          want_err;
    logic [31:0] want_rd;
`ifdef DMEM_ALIGN_CHECK_EN
    want_err = 1'b1; want_rd = 32'h0;
`else
    want_err = 1'b0; want_rd = 32'h00ABCD00;
`endif
    drive(1, 2, 0, 0, 32'h31, 32'h0000ABCD);
    model_req(2, 0, 0, 64'h31, 32'h0000ABCD, e_err, e_rd);
    tick();
    checks++; if (bus.RespError !== want_err) begin errors++; $display("FAIL misalign_err: got %b want %b", bus.RespError, want_err); end
    drive(1, 0, 3, 0, 32'h30, 32'h0);
    model_req(0, 3, 0, 64'h30, 32'h0, e_err, e_rd);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (bus.ReadData !== want_rd) begin errors++; $display("FAIL misalign_read: got %h want %h", bus.ReadData, want_rd); end
    checks++; if (bus.ErrCount !== 8'(ref_errcnt)) begin errors++; $display("FAIL misalign_count: got %0d want %0d", bus.ErrCount, ref_errcnt); end
    tick();
  endtask

  task automatic test_random();
    bit e_err; logic [31:0] e_rd;
    bit v; bit sg; int w; int r; int kind;
    logic [31:0] a; logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 4) != 0);
      kind = int'($urandom_range(0, 9));
      w = 0; r = 0;
      if (kind == 0) begin w = int'($urandom_range(1, 3)); r = int'($urandom_range(1, 3)); end
      else if (kind <= 4) w = int'($urandom_range(1, 3));
      else if (kind <= 8) r = int'($urandom_range(1, 3));
      sg = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0:       a = 32'(DEPTH - 4) + $urandom_range(0, 7);
        1:       a = $urandom();
        default: a = $urandom_range(0, 31);
      endcase
      d = $urandom();
      drive(v, w, r, sg, a, d);
      e_err = 1'b0; e_rd = 32'h0;
      if (v) model_req(w, r, sg, 64'(a), d, e_err, e_rd);
      tick();
      checks++; if (bus.RespValid !== v) begin errors++; $display("FAIL rnd_valid_%0d: got %b want %b", i, bus.RespValid, v); end
      if (v) begin
        checks++; if (bus.RespError !== e_err) begin errors++; $display("FAIL rnd_err_%0d: got %b want %b (w=%0d r=%0d a=%h)", i, bus.RespError, e_err, w, r, a); end
        checks++; if (bus.ReadData !== e_rd) begin errors++; $display("FAIL rnd_data_%0d: got %h want %h (w=%0d r=%0d s=%b a=%h)", i, bus.ReadData, e_rd, w, r, sg, a); end
        checks++; if (bus.ErrCount !== 8'(ref_errcnt)) begin errors++; $display("FAIL rnd_count_%0d: got %0d want %0d", i, bus.ErrCount, ref_errcnt); end
      end
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_saturation();
    bit e_err; logic [31:0] e_rd;
    for (int i = 0; i < 262; i++) begin
      drive(1, 1, 1, 0, 32'h4, 32'h0);
      model_req(1, 1, 0, 64'h4, 32'h0, e_err, e_rd);
      tick();
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (bus.ErrCount !== 8'hFF) begin errors++; $display("FAIL sat_count: got %0d want 255", bus.ErrCount); end
    checks++; if (bus.ErrCount !== 8'(ref_errcnt)) begin errors++; $display("FAIL sat_model: got %0d want %0d", bus.ErrCount, ref_errcnt); end
    tick();
  endtask

  task automatic test_reset_midresp();
    bit e_err; logic [31:0] e_rd;
    drive(1, 0, 3, 0, 32'h0, 32'h0);
    model_req(0, 3, 0, 64'h0, 32'h0, e_err, e_rd);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (bus.RespValid !== 1'b1) begin errors++; $display("FAIL midresp_before: got %b want 1", bus.RespValid); end
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL midresp_drop: got %b want 0", bus.RespValid); end
    checks++; if (bus.ErrCount !== 8'h0) begin errors++; $display("FAIL midresp_errcount: got %0d want 0", bus.ErrCount); end
    checks++; if (bus.ReqReady !== 1'b0) begin errors++; $display("FAIL midresp_ready: got %b want 0", bus.ReqReady); end
  endtask

  task automatic test_reset_midclear();
    bit e_err; logic [31:0] e_rd;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks++; if (bus.ReqReady !== 1'b0) begin errors++; $display("FAIL midclear_first_c%0d: got %b want 0", k, bus.ReqReady); end
    end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int k = 1; k <= DEPTH/4; k++) begin
      tick();
      checks++;
      if (bus.ReqReady !== ((k == DEPTH/4) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL midclear_ready_c%0d: got %b want %b", k, bus.ReqReady, (k == DEPTH/4));
      end
      checks++; if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL midclear_resp_c%0d: got %b want 0", k, bus.RespValid); end
    end
    // Array contents written before reset must be gone
    drive(1, 0, 3, 0, 32'h4, 32'h0);
    model_req(0, 3, 0, 64'h4, 32'h0, e_err, e_rd);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (bus.ReadData !== e_rd) begin errors++; $display("FAIL midclear_discard: got %h want %h", bus.ReadData, e_rd); end
    tick();
  endtask

  initial begin
    test_reset();
    test_clear_read();
    test_rw_sign();
    test_back_to_back();
    test_errors();
    test_misalign();
    test_random();
    test_saturation();
    test_reset_midresp();
    test_reset_midclear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
